mux_nx_pipe: RTL and testbench

//   Parametrised N-way, WIDTH-bit registered mux with valid/ready handshake
//   and a 2-entry skid buffer. It replaces combinational mux2x32/mux4x32

---
 rtl/mux_nx_pipe.sv | 117 +++++++++++
 tb/tb_mux_nx_pipe.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux_nx_pipe.sv
// N-way registered mux with valid/ready handshake and a 2-entry skid buffer.
// Optional sticky out-of-range select flag: define MUX_SEL_CHECK_EN.
module mux_nx_pipe #(
    parameter  int unsigned WIDTH = 32,
    parameter  int unsigned N     = 4,
    localparam int unsigned SW    = (N <= 2) ? 1 : $clog2(N)
) (
    input  logic               clk,
    input  logic               clrn,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SW-1:0]      sel,
    input  logic [N*WIDTH-1:0] din,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   y,
    output logic [SW-1:0]      y_sel,
    output logic               err
);

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d, skid_q, skid_d;
    logic [SW-1:0]    msel_q, msel_d, ssel_q, ssel_d;
    logic             rdy_q;
    logic [WIDTH-1:0] pick;
    logic             in_xfer, out_xfer;

    assign in_xfer   = in_valid & rdy_q;
    assign out_xfer  = (state_q != EMPTY) & out_ready;
    assign in_ready  = rdy_q;
    assign out_valid = (state_q != EMPTY);
    assign y         = main_q;
    assign y_sel     = msel_q;

    // An out-of-range select matches no channel and so yields zero.
    always_comb begin
        pick = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (32'(sel) == k) pick = din[k*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        msel_d  = msel_q;
        skid_d  = skid_q;
        ssel_d  = ssel_q;
        case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    main_d  = pick;
                    msel_d  = sel;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (in_xfer && out_xfer) begin
                    main_d = pick;
                    msel_d = sel;
                end else if (in_xfer) begin
                    skid_d  = pick;
                    ssel_d  = sel;
                    state_d = TWO;
                end else if (out_xfer) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (out_xfer) begin
                    main_d  = skid_q;
                    msel_d  = ssel_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // in_ready is registered from the next state, so out_ready never reaches it combinationally.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q <= EMPTY;
            main_q  <= '0;
            msel_q  <= '0;
            skid_q  <= '0;
            ssel_q  <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            msel_q  <= msel_d;
            skid_q  <= skid_d;
            ssel_q  <= ssel_d;
            rdy_q   <= (state_d != TWO);
        end
    end

`ifdef MUX_SEL_CHECK_EN
    logic err_q;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            err_q <= 1'b0;
        end else if (in_xfer && (32'(sel) >= N)) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mux_nx_pipe.sv
// Bench for mux_nx_pipe: queue-based reference model checked every cycle,
// plus directed vectors with literal expectations (N=4 and N=3 instances).
module tb_mux_nx_pipe;

    logic clk  = 1'b0;
    logic clrn = 1'b0;
    always #5 clk = ~clk;

    // N=4 instance
    logic         in_valid, in_ready, out_valid, out_ready, err;
    logic [1:0]   sel, y_sel;
    logic [127:0] din;
    logic [31:0]  y;

    // N=3 instance
    logic         in_valid3, in_ready3, out_valid3, out_ready3, err3;
    logic [1:0]   sel3, y_sel3;
    logic [95:0]  din3;
    logic [31:0]  y3;

    mux_nx_pipe #(.WIDTH(32), .N(4)) u4 (
        .clk(clk), .clrn(clrn), .in_valid(in_valid), .in_ready(in_ready),
        .sel(sel), .din(din), .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .y_sel(y_sel), .err(err)
    );

    mux_nx_pipe #(.WIDTH(32), .N(3)) u3 (
        .clk(clk), .clrn(clrn), .in_valid(in_valid3), .in_ready(in_ready3),
        .sel(sel3), .din(din3), .out_valid(out_valid3), .out_ready(out_ready3),
        .y(y3), .y_sel(y_sel3), .err(err3)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_out   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected word: channel sel of din, or zero when sel names no channel.
    function automatic logic [33:0] ref_word(input logic [127:0] d, input logic [1:0] s, input int nch);
        logic [31:0] w;
        w = 32'h0;
        if (int'(s) < nch) w = d[32*int'(s) +: 32];
        return {s, w};
    endfunction

    // Model: a FIFO of at most two words; in_ready true once started and not full.
    logic [33:0] q[$];
    bit          started = 1'b0;

    always @(negedge clk) begin
        bit exp_rdy, in_x, out_x;
        if (!clrn) begin
            q.delete();
            started = 1'b0;
            chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
            chk("rst_in_ready", {63'b0, in_ready}, 64'd0);
        end else begin
            exp_rdy = started && (q.size() < 2);
            chk("in_ready", {63'b0, in_ready}, {63'b0, exp_rdy});
            chk("out_valid", {63'b0, out_valid}, {63'b0, q.size() != 0});
            chk("err", {63'b0, err}, 64'd0);
            if (q.size() != 0) begin
                chk("y", {32'b0, y}, {32'b0, q[0][31:0]});
                chk("y_sel", {62'b0, y_sel}, {62'b0, q[0][33:32]});
            end
            out_x = (q.size() != 0) && out_ready;
            in_x  = in_valid && exp_rdy;
            if (out_x) begin
                void'(q.pop_front());
                n_out++;
            end
            if (in_x) q.push_back(ref_word(din, sel, 4));
            started = 1'b1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int pushed, cyc, out_base;
        bit acc;
        logic [31:0] exp2 [4];
        logic        exp_err;
        exp2[0] = 32'h7; exp2[1] = 32'h5; exp2[2] = 32'hA; exp2[3] = 32'hF;
`ifdef MUX_SEL_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif

        in_valid = 0; out_ready = 1; sel = 0;
        din = {32'hF, 32'hA, 32'h5, 32'h7};
        in_valid3 = 0; out_ready3 = 1; sel3 = 0;
        din3 = {32'hA, 32'h5, 32'h7};

        // 1: reset, single pulse
        step(); step();
        chk("t1_rst_y", {32'b0, y}, 64'd0);
        chk("t1_rst_ysel", {62'b0, y_sel}, 64'd0);
        chk("t1_rst_ov", {63'b0, out_valid}, 64'd0);
        chk("t1_rst_err", {63'b0, err}, 64'd0);
        clrn = 1;
        step();
        chk("t1_ready_after_rel", {63'b0, in_ready}, 64'd1);
        in_valid = 1; sel = 1;
        step();
        in_valid = 0;
        chk("t1_y", {32'b0, y}, 64'h5);
        chk("t1_ysel", {62'b0, y_sel}, 64'd1);
        chk("t1_ov", {63'b0, out_valid}, 64'd1);
        step();
        chk("t1_ov_one_cycle", {63'b0, out_valid}, 64'd0);

        // 2: streaming
        in_valid = 1;
        for (int i = 0; i < 4; i++) begin
            sel = 2'(i);
            step();
            chk("t2_y", {32'b0, y}, {32'b0, exp2[i]});
            chk("t2_in_ready", {63'b0, in_ready}, 64'd1);
        end
        in_valid = 0;
        step();
        chk("t2_drained", {63'b0, out_valid}, 64'd0);

        // 3: back-pressure fills the skid
        out_ready = 0; in_valid = 1; sel = 2;
        step();
        sel = 3;
        step();
        in_valid = 0;
        chk("t3_in_ready_full", {63'b0, in_ready}, 64'd0);
        chk("t3_y_held", {32'b0, y}, 64'hA);
        step();
        chk("t3_y_still", {32'b0, y}, 64'hA);
        chk("t3_ysel_still", {62'b0, y_sel}, 64'd2);
        out_ready = 1;
        step();
        chk("t3_y_second", {32'b0, y}, 64'hF);
        chk("t3_ready_back", {63'b0, in_ready}, 64'd1);
        step();
        chk("t3_empty", {63'b0, out_valid}, 64'd0);

        // 4: random handshakes, 1000 words
        pushed = 0; cyc = 0; out_base = n_out;
        while (pushed < 1000 && cyc < 20000) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            sel       = 2'($urandom_range(0, 3));
            din       = {$urandom, $urandom, $urandom, $urandom};
            acc       = in_valid && in_ready;
            step();
            cyc++;
            if (acc) pushed++;
        end
        chk("t4_pushed", 64'(pushed), 64'd1000);
        in_valid = 0; out_ready = 1;
        repeat (3) step();
        chk("t4_words_out", 64'(n_out - out_base), 64'd1000);
        chk("t4_empty", {63'b0, out_valid}, 64'd0);

        // 6: reset while in TWO
        din = {32'hF, 32'hA, 32'h5, 32'h7};
        out_ready = 0; in_valid = 1; sel = 0;
        step();
        sel = 1;
        step();
        in_valid = 0;
        chk("t6_full", {63'b0, in_ready}, 64'd0);
        #2;
        clrn = 0;
        #1;
        chk("t6_ov", {63'b0, out_valid}, 64'd0);
        chk("t6_y", {32'b0, y}, 64'd0);
        chk("t6_err", {63'b0, err}, 64'd0);
        step(); step();
        clrn = 1;
        step();
        chk("t6_ready", {63'b0, in_ready}, 64'd1);
        out_ready = 1; in_valid = 1; sel = 2;
        step();
        in_valid = 0;
        chk("t6_y_new", {32'b0, y}, 64'hA);
        chk("t6_ysel_new", {62'b0, y_sel}, 64'd2);
        step();
        chk("t6_alone", {63'b0, out_valid}, 64'd0);

        // 5: N=3, out-of-range select
        chk("t5_ready", {63'b0, in_ready3}, 64'd1);
        in_valid3 = 1; sel3 = 3;
        step();
        chk("t5_y_oob", {32'b0, y3}, 64'd0);
        chk("t5_ysel_oob", {62'b0, y_sel3}, 64'd3);
        chk("t5_ov", {63'b0, out_valid3}, 64'd1);
        chk("t5_err", {63'b0, err3}, {63'b0, exp_err});
        sel3 = 2;
        step();
        in_valid3 = 0;
        chk("t5_y_valid", {32'b0, y3}, 64'hA);
        chk("t5_err_sticky", {63'b0, err3}, {63'b0, exp_err});
        step();
        chk("t5_err_sticky2", {63'b0, err3}, {63'b0, exp_err});
        chk("t5_drained", {63'b0, out_valid3}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
